// File: rtl/bcd_counter_if.sv
// Control and status bundle for the four-digit BCD counter.
// The master drives the step/load/clear controls; the counter (slave) returns count and flags.
interface bcd_counter_if;
    logic        cnt_en;
    logic        run;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic        tc;
    logic        ovf;

    modport master (
        output cnt_en, run, up_dn, clr, load, load_val,
        input  bcd, tc, ovf
    );

    modport slave (
        input  cnt_en, run, up_dn, clr, load, load_val,
        output bcd, tc, ovf
    );
endinterface

// File: rtl/bcd_counter.sv
// Four-digit BCD up/down counter with load, clear, terminal-count pulse and sticky boundary flag.
// Carry/borrow ripples through all four digits combinationally, so a step settles in one clock.
module bcd_counter #(
    parameter bit          WRAP     = 1'b1,
    parameter logic [15:0] INIT_VAL = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_counter_if.slave  bus
);

    logic [15:0] bcd_reg, bcd_next;
    logic        tc_reg, tc_next;
    logic        ovf_reg, ovf_next;

    logic [15:0] load_clean;
    logic [15:0] step_val;
    logic [4:0]  chain;
    logic        step;
    logic        boundary;

    assign step     = bus.run & bus.cnt_en & ~bus.clr & ~bus.load;
    assign chain[0] = 1'b1;
    // Carry (up) or borrow (down) out of the thousands digit means the whole count sat at 9999/0000.
    assign boundary = chain[4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] dig;
            logic [3:0] raw;
            logic       at_edge;

            assign dig     = bcd_reg[gi*4 +: 4];
            assign raw     = bus.load_val[gi*4 +: 4];
            assign at_edge = bus.up_dn ? (dig == 4'd9) : (dig == 4'd0);

            assign load_clean[gi*4 +: 4] = (raw > 4'd9) ? 4'd0 : raw;
            assign chain[gi+1]           = chain[gi] & at_edge;
            assign step_val[gi*4 +: 4]   = !chain[gi] ? dig :
                                           at_edge    ? (bus.up_dn ? 4'd0 : 4'd9) :
                                           bus.up_dn  ? dig + 4'd1 : dig - 4'd1;
        end
    endgenerate

    always_comb begin
        bcd_next = bcd_reg;
        tc_next  = 1'b0;
        ovf_next = ovf_reg;
        if (bus.clr) begin
            bcd_next = 16'h0000;
            ovf_next = 1'b0;
        end else if (bus.load) begin
            bcd_next = load_clean;
        end else if (step) begin
            if (boundary) begin
                tc_next  = 1'b1;
                ovf_next = 1'b1;
                if (WRAP) begin
                    bcd_next = step_val;
                end
            end else begin
                bcd_next = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= INIT_VAL;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            bcd_reg <= bcd_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign bus.bcd = bcd_reg;
    assign bus.tc  = tc_reg;
    assign bus.ovf = ovf_reg;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: a wrapping instance (INIT_VAL=0042) and a saturating instance.
module tb_bcd_counter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_counter_if ifw ();
    bcd_counter_if ifs ();

    bcd_counter #(.WRAP(1'b1), .INIT_VAL(16'h0042)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifw.slave)
    );

    bcd_counter #(.WRAP(1'b0), .INIT_VAL(16'h0000)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs.slave)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one active edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ifw.cnt_en = 0; ifw.run = 0; ifw.up_dn = 1; ifw.clr = 0; ifw.load = 0; ifw.load_val = 16'h0000;
        ifs.cnt_en = 0; ifs.run = 0; ifs.up_dn = 1; ifs.clr = 0; ifs.load = 0; ifs.load_val = 16'h0000;

        #12;
        check("rst_bcd_w", ifw.bcd, 16'h0042);
        check("rst_tc_w",  {15'd0, ifw.tc}, 16'h0000);
        check("rst_ovf_w", {15'd0, ifw.ovf}, 16'h0000);
        check("rst_bcd_s", ifs.bcd, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("hold_bcd_w", ifw.bcd, 16'h0042);

        // Up ripple 0999 -> 1000
        ifw.load = 1; ifw.load_val = 16'h0999;
        tick();
        ifw.load = 0;
        check("load_0999", ifw.bcd, 16'h0999);
        ifw.run = 1; ifw.up_dn = 1; ifw.cnt_en = 1;
        tick();
        ifw.cnt_en = 0;
        check("ripple_up", ifw.bcd, 16'h1000);
        check("ripple_tc", {15'd0, ifw.tc}, 16'h0000);

        // Up wrap 9999 -> 0000
        ifw.load = 1; ifw.load_val = 16'h9999;
        tick();
        ifw.load = 0;
        check("pre_wrap_ovf", {15'd0, ifw.ovf}, 16'h0000);
        ifw.cnt_en = 1;
        tick();
        ifw.cnt_en = 0;
        check("wrap_up_bcd", ifw.bcd, 16'h0000);
        check("wrap_up_tc",  {15'd0, ifw.tc}, 16'h0001);
        check("wrap_up_ovf", {15'd0, ifw.ovf}, 16'h0001);
        tick();
        check("tc_one_cycle", {15'd0, ifw.tc}, 16'h0000);
        check("ovf_sticky",   {15'd0, ifw.ovf}, 16'h0001);

        // Down wrap 0000 -> 9999
        ifw.up_dn = 0; ifw.cnt_en = 1;
        tick();
        ifw.cnt_en = 0;
        check("wrap_dn_bcd", ifw.bcd, 16'h9999);
        check("wrap_dn_tc",  {15'd0, ifw.tc}, 16'h0001);
        tick();
        check("wrap_dn_tc0", {15'd0, ifw.tc}, 16'h0000);

        // Load beats step; then held cnt_en gives one step per cycle with borrow ripple
        ifw.load = 1; ifw.load_val = 16'h1000; ifw.cnt_en = 1;
        tick();
        ifw.load = 0;
        check("load_over_step", ifw.bcd, 16'h1000);
        tick();
        check("down_borrow", ifw.bcd, 16'h0999);
        tick();
        check("down_n2", ifw.bcd, 16'h0998);
        tick();
        ifw.cnt_en = 0;
        check("down_n3", ifw.bcd, 16'h0997);
        check("ovf_after_load", {15'd0, ifw.ovf}, 16'h0001);

        // clr > load > step
        ifw.clr = 1; ifw.load = 1; ifw.load_val = 16'h1234; ifw.cnt_en = 1;
        tick();
        ifw.clr = 0; ifw.cnt_en = 0;
        check("prio_bcd", ifw.bcd, 16'h0000);
        check("prio_ovf", {15'd0, ifw.ovf}, 16'h0000);
        check("prio_tc",  {15'd0, ifw.tc}, 16'h0000);
        tick();
        ifw.load = 0;
        check("load_1234", ifw.bcd, 16'h1234);

        // Invalid nibbles load as zero
        ifw.load = 1; ifw.load_val = 16'hA5F3;
        tick();
        ifw.load = 0;
        check("load_invalid", ifw.bcd, 16'h0503);

        // Pause: pulses ignored and not queued
        ifw.run = 0; ifw.cnt_en = 1;
        for (int i = 0; i < 5; i++) tick();
        ifw.cnt_en = 0;
        check("pause_bcd", ifw.bcd, 16'h0503);
        ifw.run = 1;
        tick();
        check("no_queue", ifw.bcd, 16'h0503);

        // Direction sampled on the same edge as the step
        ifw.up_dn = 1; ifw.cnt_en = 1;
        tick();
        ifw.cnt_en = 0;
        check("dir_same_edge", ifw.bcd, 16'h0504);

        // Saturating instance: down at 0000 holds with a tc per step
        ifs.run = 1; ifs.up_dn = 0; ifs.cnt_en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_dn_bcd", ifs.bcd, 16'h0000);
            check("sat_dn_tc",  {15'd0, ifs.tc}, 16'h0001);
        end
        ifs.cnt_en = 0;
        tick();
        check("sat_tc_end", {15'd0, ifs.tc}, 16'h0000);
        check("sat_ovf",    {15'd0, ifs.ovf}, 16'h0001);
        ifs.load = 1; ifs.load_val = 16'h9999;
        tick();
        ifs.load = 0; ifs.up_dn = 1; ifs.cnt_en = 1;
        tick();
        ifs.cnt_en = 0;
        check("sat_up_bcd", ifs.bcd, 16'h9999);
        check("sat_up_tc",  {15'd0, ifs.tc}, 16'h0001);

        // Async reset between edges, right after a wrap pulse
        ifw.load = 1; ifw.load_val = 16'h9999;
        tick();
        ifw.load = 0; ifw.cnt_en = 1;
        tick();
        check("pre_rst_tc", {15'd0, ifw.tc}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bcd", ifw.bcd, 16'h0042);
        check("async_tc",  {15'd0, ifw.tc}, 16'h0000);
        check("async_ovf", {15'd0, ifw.ovf}, 16'h0000);
        tick();
        check("rst_held_bcd", ifw.bcd, 16'h0042);
        #4;
        rst_n = 1'b1;
        tick();
        check("first_step", ifw.bcd, 16'h0043);
        check("first_tc",   {15'd0, ifw.tc}, 16'h0000);
        ifw.cnt_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
